ghr_checkpoint_queue: RTL and testbench

Circular buffer of global-history snapshots, one per in-flight predicted branch. It drives the restore side of the speculative GHR.
- At predict time, front-end allocates an entry holding the pre-update GHR and receives a tag.
- At execute time, branch unit resolves by tag. On mispredict the queue emits snapshot + actual outcome + restore pulse and discards all younger checkpoints.
- ROB commit frees entries in order from head.

---
 rtl/ghr_checkpoint_queue.sv | 117 +++++++++++
 tb/tb_ghr_checkpoint_queue.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghr_checkpoint_queue.sv
// Checkpoint queue of global-history snapshots for in-flight predicted branches.
// Mispredicts restore a snapshot one cycle later; commits retire in order from head.
module ghr_checkpoint_queue #(
  parameter int GHR_SIZE = 9,
  parameter int DEPTH    = 8,
  parameter int TAG_W    = $clog2(DEPTH)
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                alloc_valid,
  input  logic [GHR_SIZE-1:0] alloc_ghr,
  output logic                alloc_ready,
  output logic [TAG_W-1:0]    alloc_tag,
  input  logic                resolve_valid,
  input  logic [TAG_W-1:0]    resolve_tag,
  input  logic                resolve_mispredict,
  input  logic                resolve_taken,
  input  logic                commit_valid,
  output logic                head_resolved,
  output logic [TAG_W:0]      count,
  output logic                restore_ghr,
  output logic [GHR_SIZE-1:0] ghr_snap,
  output logic                actual_taken
);

  typedef logic [TAG_W:0] ptr_t;

  logic [GHR_SIZE-1:0] ghr_q [DEPTH];
  logic [DEPTH-1:0]    valid_q;
  logic [DEPTH-1:0]    resolved_q;
  logic [DEPTH-1:0]    valid_nxt;
  logic [DEPTH-1:0]    resolved_nxt;
  logic [DEPTH-1:0]    flush;
  ptr_t                head_q;
  ptr_t                tail_q;
  ptr_t                mis_tail;
  logic [TAG_W-1:0]    head_idx;
  logic [TAG_W-1:0]    mis_off;
  logic                full;
  logic                res_hit;
  logic                mis_hit;
  logic                alloc_fire;
  logic                commit_fire;

  assign head_idx      = head_q[TAG_W-1:0];
  assign count         = tail_q - head_q;
  assign full          = (count == ptr_t'(DEPTH));
  assign res_hit       = resolve_valid && valid_q[resolve_tag];
  assign mis_hit       = res_hit && resolve_mispredict;
  assign alloc_ready   = !full && !mis_hit;
  assign alloc_tag     = tail_q[TAG_W-1:0];
  assign alloc_fire    = alloc_valid && alloc_ready;
  assign head_resolved = valid_q[head_idx] && resolved_q[head_idx];
  assign commit_fire   = commit_valid && head_resolved;

  // Age of the mispredicted entry relative to head; new tail sits just past it
  // and inherits head's wrap bit through the full-width add.
  assign mis_off  = resolve_tag - head_idx;
  assign mis_tail = head_q + ptr_t'(mis_off) + ptr_t'(1);

  always_comb begin
    flush = '0;
    for (int i = 0; i < DEPTH; i++) begin
      flush[i] = mis_hit && ((TAG_W'(i) - head_idx) > mis_off);
    end
  end

  always_comb begin
    valid_nxt    = valid_q & ~flush;
    resolved_nxt = resolved_q & ~flush;
    if (res_hit) begin
      resolved_nxt[resolve_tag] = 1'b1;
    end
    if (alloc_fire) begin
      valid_nxt[alloc_tag]    = 1'b1;
      resolved_nxt[alloc_tag] = 1'b0;
    end
    if (commit_fire) begin
      valid_nxt[head_idx]    = 1'b0;
      resolved_nxt[head_idx] = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      valid_q      <= '0;
      resolved_q   <= '0;
      restore_ghr  <= 1'b0;
      ghr_snap     <= '0;
      actual_taken <= 1'b0;
    end else begin
      valid_q     <= valid_nxt;
      resolved_q  <= resolved_nxt;
      restore_ghr <= mis_hit;
      if (mis_hit) begin
        ghr_snap     <= ghr_q[resolve_tag];
        actual_taken <= resolve_taken;
        tail_q       <= mis_tail;
      end else if (alloc_fire) begin
        tail_q <= tail_q + ptr_t'(1);
      end
      if (commit_fire) begin
        head_q <= head_q + ptr_t'(1);
      end
    end
  end

  // Snapshot storage needs no reset: an entry is only read while valid.
  always_ff @(posedge CLK) begin
    if (alloc_fire) begin
      ghr_q[alloc_tag] <= alloc_ghr;
    end
  end

endmodule

// File: tb/tb_ghr_checkpoint_queue.sv
// Bench for ghr_checkpoint_queue: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_ghr_checkpoint_queue;

  localparam int GS    = 9;
  localparam int DEPTH = 8;
  localparam int TW    = 3;

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic          alloc_valid = 1'b0;
  logic [GS-1:0] alloc_ghr = '0;
  logic          alloc_ready;
  logic [TW-1:0] alloc_tag;
  logic          resolve_valid = 1'b0;
  logic [TW-1:0] resolve_tag = '0;
  logic          resolve_mispredict = 1'b0;
  logic          resolve_taken = 1'b0;
  logic          commit_valid = 1'b0;
  logic          head_resolved;
  logic [TW:0]   count;
  logic          restore_ghr;
  logic [GS-1:0] ghr_snap;
  logic          actual_taken;

  ghr_checkpoint_queue #(.GHR_SIZE(GS), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ghr(alloc_ghr),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
    .resolve_mispredict(resolve_mispredict), .resolve_taken(resolve_taken),
    .commit_valid(commit_valid), .head_resolved(head_resolved),
    .count(count), .restore_ghr(restore_ghr),
    .ghr_snap(ghr_snap), .actual_taken(actual_taken)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  typedef struct packed {
    logic [GS-1:0] ghr;
    logic          res;
  } ent_t;

  ent_t          q[$];
  int            m_head = 0;
  bit            m_restore = 1'b0;
  logic [GS-1:0] m_snap = '0;
  bit            m_taken = 1'b0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endfunction

  function automatic int pos_of(logic [TW-1:0] t);
    return (int'(t) - m_head + DEPTH) % DEPTH;
  endfunction

  function automatic bit m_ready();
    bit hit;
    hit = resolve_valid && resolve_mispredict
          && (pos_of(resolve_tag) < q.size());
    return (q.size() < DEPTH) && !hit;
  endfunction

  // Reference model: ordered list of in-flight branches, oldest first.
  always @(posedge CLK) begin
    int  p;
    bit  ar;
    bit  hr;
    if (reset) begin
      q.delete();
      m_head    = 0;
      m_restore = 1'b0;
      m_snap    = '0;
      m_taken   = 1'b0;
    end else begin
      ar = m_ready();
      hr = (q.size() > 0) && q[0].res;
      p  = pos_of(resolve_tag);
      m_restore = 1'b0;
      if (resolve_valid && p < q.size()) begin
        q[p].res = 1'b1;
        if (resolve_mispredict) begin
          m_restore = 1'b1;
          m_snap    = q[p].ghr;
          m_taken   = resolve_taken;
          while (q.size() > p + 1) void'(q.pop_back());
        end
      end
      if (alloc_valid && ar) q.push_back('{ghr: alloc_ghr, res: 1'b0});
      if (commit_valid && hr) begin
        void'(q.pop_front());
        m_head = (m_head + 1) % DEPTH;
      end
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("count", int'(count), q.size());
      chk("alloc_ready", int'(alloc_ready), int'(m_ready()));
      if (alloc_valid && alloc_ready)
        chk("alloc_tag", int'(alloc_tag), (m_head + q.size()) % DEPTH);
      chk("head_resolved", int'(head_resolved),
          int'((q.size() > 0) && q[0].res));
      chk("restore_ghr", int'(restore_ghr), int'(m_restore));
      chk("ghr_snap", int'(ghr_snap), int'(m_snap));
      chk("actual_taken", int'(actual_taken), int'(m_taken));
    end
  end

  task automatic step(input bit r, input bit av, input logic [GS-1:0] g,
                      input bit rv, input logic [TW-1:0] rt, input bit rm,
                      input bit rk, input bit cv);
    @(posedge CLK);
    #1;
    reset = r;
    alloc_valid = av;
    alloc_ghr = g;
    resolve_valid = rv;
    resolve_tag = rt;
    resolve_mispredict = rm;
    resolve_taken = rk;
    commit_valid = cv;
    @(negedge CLK);
  endtask

  task automatic idle();
    step(0, 0, '0, 0, '0, 0, 0, 0);
  endtask

  task automatic rst();
    step(1, 0, '0, 0, '0, 0, 0, 0);
  endtask

  task automatic alloc(input logic [GS-1:0] g);
    step(0, 1, g, 0, '0, 0, 0, 0);
  endtask

  task automatic resolve(input logic [TW-1:0] t, input bit m, input bit k);
    step(0, 0, '0, 1, t, m, k, 0);
  endtask

  task automatic commit();
    step(0, 0, '0, 0, '0, 0, 0, 1);
  endtask

  initial begin
    rst();
    rst();
    cmp_en = 1'b1;
    idle();
    chk("rst_count", int'(count), 0);
    chk("rst_restore", int'(restore_ghr), 0);
    chk("rst_ready", int'(alloc_ready), 1);
    chk("rst_snap", int'(ghr_snap), 0);

    for (int i = 0; i < 8; i++) begin
      alloc(GS'(i + 1));
      chk("fill_tag", int'(alloc_tag), i);
    end
    alloc(9'h009);
    chk("full_ready", int'(alloc_ready), 0);
    chk("full_count", int'(count), 8);
    idle();
    chk("drop_count", int'(count), 8);

    resolve(3'd0, 0, 0);
    step(0, 0, '0, 1, 3'd1, 0, 0, 1);
    commit();
    idle();
    chk("commit_count", int'(count), 6);
    chk("commit_head_res", int'(head_resolved), 0);
    alloc(9'h010);
    chk("wrap_tag0", int'(alloc_tag), 0);
    alloc(9'h011);
    chk("wrap_tag1", int'(alloc_tag), 1);
    idle();
    chk("wrap_count", int'(count), 8);

    rst();
    for (int i = 0; i < 5; i++) begin
      alloc(GS'(9'h0A0 + i));
      chk("mis_fill_tag", int'(alloc_tag), i);
    end
    resolve(3'd2, 1, 1);
    chk("mis_ready", int'(alloc_ready), 0);
    idle();
    chk("mis_restore", int'(restore_ghr), 1);
    chk("mis_snap", int'(ghr_snap), 'h0A2);
    chk("mis_taken", int'(actual_taken), 1);
    chk("mis_count", int'(count), 3);
    chk("mis_next_tag", int'(alloc_tag), 3);
    idle();
    chk("mis_pulse_end", int'(restore_ghr), 0);
    chk("mis_snap_hold", int'(ghr_snap), 'h0A2);

    step(0, 1, 9'h055, 1, 3'd1, 1, 0, 0);
    chk("mis_alloc_block", int'(alloc_ready), 0);
    idle();
    chk("mis2_count", int'(count), 2);
    chk("mis2_tail", int'(alloc_tag), 2);
    chk("mis2_snap", int'(ghr_snap), 'h0A1);
    chk("mis2_taken", int'(actual_taken), 0);

    rst();
    for (int i = 0; i < 4; i++) alloc(GS'(9'h100 + i));
    for (int i = 0; i < 4; i++) resolve(TW'(i), 0, 0);
    for (int i = 0; i < 4; i++) commit();
    for (int i = 4; i < 7; i++) begin
      alloc(GS'(9'h1B0 + i));
      chk("head4_tag", int'(alloc_tag), i);
    end
    resolve(3'd4, 0, 0);
    step(0, 0, '0, 1, 3'd4, 1, 1, 1);
    idle();
    chk("cm_count", int'(count), 0);
    chk("cm_restore", int'(restore_ghr), 1);
    chk("cm_snap", int'(ghr_snap), 'h1B4);
    chk("cm_tail", int'(alloc_tag), 5);

    resolve(3'd4, 1, 0);
    idle();
    chk("freed_restore", int'(restore_ghr), 0);
    chk("freed_count", int'(count), 0);
    chk("freed_snap", int'(ghr_snap), 'h1B4);

    for (int i = 0; i < 3; i++) alloc(GS'(9'h020 + i));
    rst();
    idle();
    chk("rst3_count", int'(count), 0);
    chk("rst3_restore", int'(restore_ghr), 0);

    alloc(9'h0C0);
    alloc(9'h0C1);
    resolve(3'd0, 1, 1);
    rst();
    chk("pre_rst_restore", int'(restore_ghr), 1);
    idle();
    chk("midrst_restore", int'(restore_ghr), 0);
    chk("midrst_count", int'(count), 0);
    chk("midrst_snap", int'(ghr_snap), 0);

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) < 6), GS'($urandom),
           ($urandom_range(0, 9) < 4), TW'($urandom),
           ($urandom_range(0, 3) == 0), 1'($urandom),
           ($urandom_range(0, 1) == 1));
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
